// File: rtl/rv_exec_issue.sv
// rv_exec_issue: single-entry execute issue stage.
// Holds one decoded instruction. Register operands are resolved from a
// prioritised forwarding network (source 0 is the youngest), and the
// jump/branch target is computed from the resolved values.
// A one-cycle bubble is inserted when the instruction in the stage is a load
// whose destination is read by the incoming instruction.
// Optional feature macro: RV_EXEC_MISALIGN_TRAP_EN adds the misaligned
// jump-target trap output; without it o_to_trap is tied low.
module rv_exec_issue #(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int NUM_FWD          = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_valid,
  input  logic                          i_ready,
  input  logic [IADDR_SPACE_BITS-1:0]   i_pc,
  input  logic [IADDR_SPACE_BITS-1:0]   i_pc_next,
  input  logic [4:0]                    i_rs1,
  input  logic [4:0]                    i_rs2,
  input  logic [4:0]                    i_rd,
  input  logic [31:0]                   i_imm_i,
  input  logic [31:0]                   i_imm_j,
  input  logic                          i_op1_src,
  input  logic [1:0]                    i_op2_sel,
  input  logic                          i_res_load,
  input  logic                          i_reg_write,
  input  logic                          i_inst_jal,
  input  logic                          i_inst_jalr,
  input  logic                          i_inst_mret,
  input  logic                          i_inst_branch,
  input  logic                          i_inst_store,
  input  logic [IADDR_SPACE_BITS-1:0]   i_ret_addr,
  input  logic [31:0]                   i_reg1_data,
  input  logic [31:0]                   i_reg2_data,
  input  logic [NUM_FWD-1:0]            i_fwd_valid,
  input  logic [5*NUM_FWD-1:0]          i_fwd_rd,
  input  logic [32*NUM_FWD-1:0]         i_fwd_data,
  output logic [31:0]                   o_op1,
  output logic [31:0]                   o_op2,
  output logic [31:0]                   o_rs1_val,
  output logic [31:0]                   o_rs2_val,
  output logic [4:0]                    o_rd,
  output logic                          o_reg_write,
  output logic                          o_store,
  output logic                          o_res_load,
  output logic                          o_inst_jal_jalr,
  output logic                          o_inst_branch,
  output logic [IADDR_SPACE_BITS-1:0]   o_pc,
  output logic [IADDR_SPACE_BITS-1:0]   o_pc_next,
  output logic [IADDR_SPACE_BITS-1:0]   o_pc_target,
  output logic                          o_to_trap,
  output logic [31:0]                   o_stall_cnt
);

  localparam int W = IADDR_SPACE_BITS;

  // control state (reset)
  logic        valid_q, valid_d;
  logic        res_load_q, reg_write_q, store_q;
  logic        jal_q, jalr_q, mret_q, branch_q;
  logic [4:0]  rd_q;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // data fields (no reset, qualified by valid_q)
  logic [W-1:0] pc_q, pc_next_q;
  logic [4:0]   rs1_q, rs2_q;
  logic [31:0]  imm_i_q, imm_j_q;
  logic         op1_src_q;
  logic [1:0]   op2_sel_q;

  logic         hazard;
  logic         load;
  logic         accept;
  logic [31:0]  rs1_val, rs2_val;
  logic [31:0]  pc_ext;
  logic [W-1:0] target;

  // Highest-priority (lowest index) matching forward source wins; x0 is
  // always zero and a forward to x0 never matches.
  function automatic logic [31:0] fwd_resolve(
    input logic [4:0]             rs,
    input logic [31:0]            rf_data,
    input logic [NUM_FWD-1:0]     fv,
    input logic [5*NUM_FWD-1:0]   frd,
    input logic [32*NUM_FWD-1:0]  fdata
  );
    logic [31:0] val;
    val = rf_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fv[k] && (frd[5*k +: 5] == rs) && (frd[5*k +: 5] != 5'd0)) begin
        val = fdata[32*k +: 32];
      end
    end
    if (rs == 5'd0) begin
      val = 32'd0;
    end
    return val;
  endfunction

  // Load-use hazard against the instruction currently held in the stage.
  assign hazard = valid_q & res_load_q & (rd_q != 5'd0) &
                  ((i_rs1 == rd_q) | (i_rs2 == rd_q)) & i_valid;
  assign o_ready = (!valid_q | i_ready) & !hazard;
  assign load    = i_valid & o_ready;
  // Flush overrides a same-cycle load; nothing is captured.
  assign accept  = load & !i_flush;

  // Next-state occupancy and backpressure counter.
  always_comb begin
    valid_d = valid_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !i_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid_q     <= 1'b0;
      res_load_q  <= 1'b0;
      reg_write_q <= 1'b0;
      store_q     <= 1'b0;
      jal_q       <= 1'b0;
      jalr_q      <= 1'b0;
      mret_q      <= 1'b0;
      branch_q    <= 1'b0;
      rd_q        <= 5'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (accept) begin
        res_load_q  <= i_res_load;
        reg_write_q <= i_reg_write;
        store_q     <= i_inst_store;
        jal_q       <= i_inst_jal;
        jalr_q      <= i_inst_jalr;
        mret_q      <= i_inst_mret;
        branch_q    <= i_inst_branch;
        rd_q        <= i_rd;
      end
    end
  end

  // Data fields captured on accept; held while stalled.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      pc_q      <= i_pc;
      pc_next_q <= i_pc_next;
      rs1_q     <= i_rs1;
      rs2_q     <= i_rs2;
      imm_i_q   <= i_imm_i;
      imm_j_q   <= i_imm_j;
      op1_src_q <= i_op1_src;
      op2_sel_q <= i_op2_sel;
    end
  end

  // Operand resolution through the forwarding network.
  always_comb begin
    rs1_val = fwd_resolve(rs1_q, i_reg1_data, i_fwd_valid, i_fwd_rd, i_fwd_data);
    rs2_val = fwd_resolve(rs2_q, i_reg2_data, i_fwd_valid, i_fwd_rd, i_fwd_data);
  end

  // Operand muxes; op2_sel 11 falls back to the register value.
  always_comb begin
    pc_ext         = 32'd0;
    pc_ext[W-1:0]  = pc_q;
    o_op1          = op1_src_q ? pc_ext : rs1_val;
    case (op2_sel_q)
      2'b01:   o_op2 = imm_i_q;
      2'b10:   o_op2 = imm_j_q;
      default: o_op2 = rs2_val;
    endcase
  end

  // Jump/branch target, wrapping modulo the instruction address space.
  always_comb begin
    if (mret_q) begin
      target = i_ret_addr;
    end else if (jalr_q) begin
      target    = rs1_val[W-1:0] + imm_i_q[W-1:0];
      target[0] = 1'b0;
    end else begin
      target = pc_q + imm_j_q[W-1:0];
    end
  end

  assign o_valid         = valid_q;
  assign o_rs1_val       = rs1_val;
  assign o_rs2_val       = rs2_val;
  assign o_rd            = rd_q;
  assign o_reg_write     = valid_q & reg_write_q;
  assign o_store         = valid_q & store_q;
  assign o_res_load      = valid_q & res_load_q;
  assign o_inst_jal_jalr = valid_q & (jal_q | jalr_q | mret_q);
  assign o_inst_branch   = valid_q & branch_q;
  assign o_pc            = pc_q;
  assign o_pc_next       = pc_next_q;
  assign o_pc_target     = target;
  assign o_stall_cnt     = stall_cnt_q;

`ifdef RV_EXEC_MISALIGN_TRAP_EN
  logic [31:0] target_ext;

  // Zero-extend so bit 1 exists even for a 1-bit address space.
  always_comb begin
    target_ext        = 32'd0;
    target_ext[W-1:0] = target;
  end

  assign o_to_trap = valid_q & o_inst_jal_jalr & target_ext[1];
`else
  assign o_to_trap = 1'b0;
`endif

endmodule

// File: tb/tb_rv_exec_issue.sv
// Directed testbench for rv_exec_issue: forwarding, load-use bubble,
// backpressure, targets, flush and reset.
module tb_rv_exec_issue;

  localparam int W = 32;
  localparam int NF = 2;
`ifdef RV_EXEC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset_n, i_flush, i_valid, i_ready;
  logic          o_ready, o_valid;
  logic [W-1:0]  i_pc, i_pc_next, i_ret_addr;
  logic [4:0]    i_rs1, i_rs2, i_rd;
  logic [31:0]   i_imm_i, i_imm_j, i_reg1_data, i_reg2_data;
  logic          i_op1_src;
  logic [1:0]    i_op2_sel;
  logic          i_res_load, i_reg_write, i_inst_jal, i_inst_jalr;
  logic          i_inst_mret, i_inst_branch, i_inst_store;
  logic [NF-1:0]    i_fwd_valid;
  logic [5*NF-1:0]  i_fwd_rd;
  logic [32*NF-1:0] i_fwd_data;
  logic [31:0]   o_op1, o_op2, o_rs1_val, o_rs2_val, o_stall_cnt;
  logic [4:0]    o_rd;
  logic          o_reg_write, o_store, o_res_load, o_inst_jal_jalr, o_inst_branch;
  logic [W-1:0]  o_pc, o_pc_next, o_pc_target;
  logic          o_to_trap;

  int nvec = 0;
  int nerr = 0;

  rv_exec_issue #(.IADDR_SPACE_BITS(W), .NUM_FWD(NF)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .i_pc(i_pc), .i_pc_next(i_pc_next), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_imm_i(i_imm_i), .i_imm_j(i_imm_j), .i_op1_src(i_op1_src), .i_op2_sel(i_op2_sel),
    .i_res_load(i_res_load), .i_reg_write(i_reg_write), .i_inst_jal(i_inst_jal),
    .i_inst_jalr(i_inst_jalr), .i_inst_mret(i_inst_mret), .i_inst_branch(i_inst_branch),
    .i_inst_store(i_inst_store), .i_ret_addr(i_ret_addr),
    .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data),
    .i_fwd_valid(i_fwd_valid), .i_fwd_rd(i_fwd_rd), .i_fwd_data(i_fwd_data),
    .o_op1(o_op1), .o_op2(o_op2), .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val),
    .o_rd(o_rd), .o_reg_write(o_reg_write), .o_store(o_store), .o_res_load(o_res_load),
    .o_inst_jal_jalr(o_inst_jal_jalr), .o_inst_branch(o_inst_branch),
    .o_pc(o_pc), .o_pc_next(o_pc_next), .o_pc_target(o_pc_target),
    .o_to_trap(o_to_trap), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_fields();
    i_pc = '0; i_pc_next = '0; i_rs1 = 0; i_rs2 = 0; i_rd = 0;
    i_imm_i = 0; i_imm_j = 0; i_op1_src = 0; i_op2_sel = 0;
    i_res_load = 0; i_reg_write = 0; i_inst_jal = 0; i_inst_jalr = 0;
    i_inst_mret = 0; i_inst_branch = 0; i_inst_store = 0;
  endtask

  task automatic do_reset();
    clr_fields();
    i_flush = 0; i_valid = 0; i_ready = 1;
    i_ret_addr = '0; i_reg1_data = 0; i_reg2_data = 0;
    i_fwd_valid = '0; i_fwd_rd = '0; i_fwd_data = '0;
    i_reset_n = 0;
    step();
    step();
    i_reset_n = 1;
    #1;
  endtask

  // Issue the currently driven fields, then hold the stage (i_ready=0).
  task automatic issue();
    i_valid = 1; i_ready = 1;
    step();
    i_valid = 0; i_ready = 0;
    #1;
  endtask

  task automatic test_reset();
    clr_fields();
    i_reset_n = 0; i_valid = 1; i_ready = 0; i_flush = 0; i_reg_write = 1; i_rd = 5'd9;
    i_fwd_valid = '0; i_fwd_rd = '0; i_fwd_data = '0;
    i_ret_addr = '0; i_reg1_data = 0; i_reg2_data = 0;
    step();
    step();
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b exp 0", o_valid); end
    nvec++; if (o_stall_cnt !== 32'd0) begin nerr++; $display("FAIL rst_stall: got %0d exp 0", o_stall_cnt); end
    nvec++; if (o_rd !== 5'd0) begin nerr++; $display("FAIL rst_rd: got %0d exp 0", o_rd); end
    nvec++; if (o_reg_write !== 1'b0) begin nerr++; $display("FAIL rst_regwr: got %b exp 0", o_reg_write); end
    nvec++; if (o_to_trap !== 1'b0) begin nerr++; $display("FAIL rst_trap: got %b exp 0", o_to_trap); end
    i_valid = 0; i_reset_n = 1;
    #1;
    nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b exp 1", o_ready); end
  endtask

  task automatic test_forward();
    do_reset();
    i_rs1 = 5'd5; i_rs2 = 5'd6; i_rd = 5'd1; i_reg_write = 1;
    issue();
    nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL fwd_valid: got %b exp 1", o_valid); end
    nvec++; if (o_reg_write !== 1'b1) begin nerr++; $display("FAIL fwd_regwr: got %b exp 1", o_reg_write); end
    nvec++; if (o_rd !== 5'd1) begin nerr++; $display("FAIL fwd_rd: got %0d exp 1", o_rd); end
    i_fwd_valid = 2'b11; i_fwd_rd = {5'd5, 5'd5}; i_fwd_data = {32'h22, 32'h11};
    i_reg1_data = 32'h33; i_reg2_data = 32'h44;
    #1;
    nvec++; if (o_rs1_val !== 32'h11) begin nerr++; $display("FAIL fwd_prio: got %h exp 11", o_rs1_val); end
    nvec++; if (o_op1 !== 32'h11) begin nerr++; $display("FAIL fwd_op1: got %h exp 11", o_op1); end
    i_fwd_valid = 2'b10;
    #1;
    nvec++; if (o_rs1_val !== 32'h22) begin nerr++; $display("FAIL fwd_src1: got %h exp 22", o_rs1_val); end
    i_fwd_valid = 2'b00;
    #1;
    nvec++; if (o_rs1_val !== 32'h33) begin nerr++; $display("FAIL fwd_rf: got %h exp 33", o_rs1_val); end
    i_fwd_valid = 2'b10; i_fwd_rd = {5'd6, 5'd0}; i_fwd_data = {32'h66, 32'h77};
    #1;
    nvec++; if (o_rs2_val !== 32'h66) begin nerr++; $display("FAIL fwd_rs2: got %h exp 66", o_rs2_val); end
    nvec++; if (o_op2 !== 32'h66) begin nerr++; $display("FAIL fwd_op2reg: got %h exp 66", o_op2); end
    // rs1=0 with forwards targeting x0: must read zero
    clr_fields();
    i_rs1 = 5'd0; i_op2_sel = 2'b01; i_imm_i = 32'h123;
    i_fwd_valid = 2'b11; i_fwd_rd = {5'd0, 5'd0}; i_fwd_data = {32'hAA, 32'hBB};
    i_reg1_data = 32'h55;
    issue();
    nvec++; if (o_rs1_val !== 32'h0) begin nerr++; $display("FAIL fwd_x0: got %h exp 0", o_rs1_val); end
    nvec++; if (o_op2 !== 32'h123) begin nerr++; $display("FAIL op2_immi: got %h exp 123", o_op2); end
    clr_fields();
    i_op1_src = 1; i_pc = 32'h200; i_op2_sel = 2'b10; i_imm_j = 32'h456;
    issue();
    nvec++; if (o_op1 !== 32'h200) begin nerr++; $display("FAIL op1_pc: got %h exp 200", o_op1); end
    nvec++; if (o_op2 !== 32'h456) begin nerr++; $display("FAIL op2_immj: got %h exp 456", o_op2); end
    clr_fields();
    i_rs2 = 5'd6; i_op2_sel = 2'b11; i_imm_i = 32'h999; i_imm_j = 32'h888;
    i_fwd_valid = 2'b00; i_reg2_data = 32'h44;
    issue();
    nvec++; if (o_op2 !== 32'h44) begin nerr++; $display("FAIL op2_sel11: got %h exp 44", o_op2); end
  endtask

  task automatic test_hazard();
    do_reset();
    i_res_load = 1; i_rd = 5'd7; i_reg_write = 1;
    issue();
    clr_fields();
    i_rs1 = 5'd1; i_rs2 = 5'd7; i_rd = 5'd8; i_reg_write = 1;
    i_valid = 1; i_ready = 1;
    #1;
    nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL haz_ready: got %b exp 0", o_ready); end
    step();
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL haz_bubble: got %b exp 0", o_valid); end
    nvec++; if (o_reg_write !== 1'b0) begin nerr++; $display("FAIL haz_gated: got %b exp 0", o_reg_write); end
    nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL haz_ready2: got %b exp 1", o_ready); end
    step();
    i_valid = 0;
    nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL haz_accept: got %b exp 1", o_valid); end
    nvec++; if (o_rd !== 5'd8) begin nerr++; $display("FAIL haz_rd: got %0d exp 8", o_rd); end
  endtask

  task automatic test_stall();
    do_reset();
    i_pc = 32'h40; i_pc_next = 32'h44; i_rd = 5'd3; i_reg_write = 1;
    issue();
    i_valid = 1; i_pc = 32'h99; i_rd = 5'd9;
    for (int c = 0; c < 3; c++) begin
      step();
      nvec++; if (o_pc !== 32'h40) begin nerr++; $display("FAIL stall_pc[%0d]: got %h exp 40", c, o_pc); end
      nvec++; if (o_rd !== 5'd3 || o_valid !== 1'b1) begin nerr++; $display("FAIL stall_hold[%0d]: got rd=%0d v=%b exp rd=3 v=1", c, o_rd, o_valid); end
    end
    nvec++; if (o_stall_cnt !== 32'd3) begin nerr++; $display("FAIL stall_cnt: got %0d exp 3", o_stall_cnt); end
    nvec++; if (o_pc_next !== 32'h44) begin nerr++; $display("FAIL stall_pcn: got %h exp 44", o_pc_next); end
    i_valid = 0; i_ready = 1;
    step();
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL stall_drain: got %b exp 0", o_valid); end
    nvec++; if (o_stall_cnt !== 32'd3) begin nerr++; $display("FAIL stall_cnt2: got %0d exp 3", o_stall_cnt); end
  endtask

  task automatic test_targets();
    do_reset();
    i_inst_jalr = 1; i_rs1 = 5'd2; i_imm_i = 32'h2; i_rd = 5'd1; i_reg_write = 1;
    i_reg1_data = 32'h1001;
    issue();
    nvec++; if (o_pc_target !== 32'h1002) begin nerr++; $display("FAIL jalr_tgt: got %h exp 1002", o_pc_target); end
    nvec++; if (o_inst_jal_jalr !== 1'b1) begin nerr++; $display("FAIL jalr_flag: got %b exp 1", o_inst_jal_jalr); end
    nvec++; if (o_to_trap !== TRAP_EN) begin nerr++; $display("FAIL jalr_trap: got %b exp %b", o_to_trap, TRAP_EN); end
    clr_fields();
    i_inst_jal = 1; i_pc = 32'h100; i_imm_j = 32'h20;
    issue();
    nvec++; if (o_pc_target !== 32'h120) begin nerr++; $display("FAIL jal_tgt: got %h exp 120", o_pc_target); end
    nvec++; if (o_to_trap !== 1'b0) begin nerr++; $display("FAIL jal_trap: got %b exp 0", o_to_trap); end
    clr_fields();
    i_inst_mret = 1; i_ret_addr = 32'h80; i_pc = 32'h300; i_imm_j = 32'h6;
    issue();
    nvec++; if (o_pc_target !== 32'h80) begin nerr++; $display("FAIL mret_tgt: got %h exp 80", o_pc_target); end
    nvec++; if (o_inst_jal_jalr !== 1'b1) begin nerr++; $display("FAIL mret_flag: got %b exp 1", o_inst_jal_jalr); end
    clr_fields();
    i_inst_branch = 1; i_inst_store = 1; i_pc = 32'h1000; i_imm_j = 32'hFFFF_FFF0;
    issue();
    nvec++; if (o_pc_target !== 32'hFF0) begin nerr++; $display("FAIL br_tgt: got %h exp ff0", o_pc_target); end
    nvec++; if (o_inst_branch !== 1'b1 || o_inst_jal_jalr !== 1'b0) begin nerr++; $display("FAIL br_flags: got br=%b jj=%b exp br=1 jj=0", o_inst_branch, o_inst_jal_jalr); end
    nvec++; if (o_store !== 1'b1) begin nerr++; $display("FAIL br_store: got %b exp 1", o_store); end
  endtask

  task automatic test_flush();
    do_reset();
    i_reg_write = 1; i_rd = 5'd4;
    issue();
    i_flush = 1;
    step();
    i_flush = 0;
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid: got %b exp 0", o_valid); end
    nvec++; if (o_stall_cnt !== 32'd1) begin nerr++; $display("FAIL flush_cnt: got %0d exp 1", o_stall_cnt); end
    i_valid = 1; i_flush = 1; i_ready = 1;
    #1;
    nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL flush_ready: got %b exp 1", o_ready); end
    step();
    i_valid = 0; i_flush = 0;
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL flush_load: got %b exp 0", o_valid); end
    // reset in the middle of a stall
    issue();
    step();
    step();
    nvec++; if (o_stall_cnt !== 32'd3) begin nerr++; $display("FAIL pre_rst_cnt: got %0d exp 3", o_stall_cnt); end
    i_reset_n = 0;
    step();
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL rst_mid_valid: got %b exp 0", o_valid); end
    nvec++; if (o_stall_cnt !== 32'd0) begin nerr++; $display("FAIL rst_mid_cnt: got %0d exp 0", o_stall_cnt); end
    i_reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_hazard();
    test_stall();
    test_targets();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rv_exec_issue.md
RV_EXEC_ISSUE -- requirements
Module: rv_exec_issue

Interface
REQ-001 SHALL have parameter IADDR_SPACE_BITS, default 32, instruction address width (1..32).
REQ-002 SHALL have parameter NUM_FWD, default 2, number of forwarding sources (1..4); index 0 is youngest and has highest priority.
REQ-003 SHALL have ports, one clock, reset synchronous active-low:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_flush  in  1  kill stage contents
- i_valid / o_ready  in/out  1  upstream handshake
- o_valid / i_ready  out/in  1  downstream handshake
- i_pc, i_pc_next  in  IADDR_SPACE_BITS  instruction PC, fall-through PC
- i_rs1, i_rs2, i_rd  in  5  register indices
- i_imm_i, i_imm_j  in  32  immediates
- i_op1_src  in  1  1=PC for op1
- i_op2_sel  in  2  00=reg2, 01=imm_i, 10=imm_j
- i_res_load  in  1  instruction is a load
- i_reg_write, i_inst_jal, i_inst_jalr, i_inst_mret, i_inst_branch, i_inst_store  in  1  decode flags
- i_ret_addr  in  IADDR_SPACE_BITS  mret return address
- i_reg1_data, i_reg2_data  in  32  register-file read data for registered rs1/rs2
- i_fwd_valid  in  NUM_FWD  forward source valid with reg write
- i_fwd_rd  in  5*NUM_FWD  forward destination, packed
- i_fwd_data  in  32*NUM_FWD  forward data, packed
- o_op1, o_op2  out  32  resolved operands
- o_rs1_val, o_rs2_val  out  32  forwarded register values
- o_rd, o_reg_write, o_store, o_res_load, o_inst_jal_jalr, o_inst_branch  out  registered fields
- o_pc, o_pc_next, o_pc_target  out  IADDR_SPACE_BITS  PCs and jump target
- o_to_trap  out  1  misaligned target trap (see REQ-020)
- o_stall_cnt  out  32  downstream backpressure cycle count

Function
REQ-004 SHALL hold one instruction; o_valid reflects occupancy.
REQ-005 SHALL load stage on i_valid & o_ready; o_ready = (!o_valid | i_ready) & !hazard.
REQ-006 SHALL clear o_valid when i_ready & o_valid with no new load (including hazard bubble).
REQ-007 SHALL hold all registered fields unchanged while o_valid & !i_ready.
REQ-008 SHALL detect hazard = o_valid & o_res_load & o_rd!=0 & (i_rs1==o_rd | i_rs2==o_rd) & i_valid; hazard inserts exactly one bubble.
REQ-009 SHALL resolve rsN_val: if rsN==0 then 0; else lowest index k with i_fwd_valid[k] & i_fwd_rd[k]==rsN gives i_fwd_data[k]; else i_regN_data.
REQ-010 SHALL ignore forward sources with i_fwd_rd==0.
REQ-011 SHALL set o_op1 = op1_src ? zero-extended PC : rs1_val; o_op2 = imm_i / imm_j / rs2_val per op2_sel; op2_sel=11 SHALL select rs2_val.
REQ-012 SHALL compute o_pc_target combinationally: mret -> i_ret_addr; jalr -> (rs1_val+imm_i) with bit 0 cleared; else pc+imm_j; modulo 2^IADDR_SPACE_BITS.
REQ-013 SHALL drive o_inst_jal_jalr = jal|jalr|mret, all qualified by o_valid.
REQ-014 SHALL gate o_reg_write, o_store, o_inst_* low when o_valid=0.
REQ-015 SHALL increment o_stall_cnt each cycle o_valid & !i_ready, saturating at 0xFFFFFFFF; flush does not clear it.
REQ-016 i_flush SHALL clear o_valid next cycle and override a simultaneous load; o_ready unaffected.

Reset
REQ-017 i_reset_n=0 at clock edge SHALL clear o_valid, all flags, o_rd, o_to_trap and o_stall_cnt to 0; reset mid-transfer drops the instruction.
REQ-018 Data fields (PC, immediates, indices) SHALL need no reset; outputs qualified by o_valid.
REQ-019 o_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-020 With RV_EXEC_MISALIGN_TRAP_EN defined, o_to_trap SHALL = o_valid & o_inst_jal_jalr & o_pc_target[1]; without it, o_to_trap SHALL be constant 0 and no comparison logic exists.

Verification
REQ-021 rs1=5, fwd0 rd=5 data=0x11, fwd1 rd=5 data=0x22, regfile 0x33 -> o_rs1_val=0x11; drop fwd0 -> 0x22; rs1=0 -> 0.
REQ-022 load rd=7 in stage, i_valid with rs2=7 -> o_ready=0 one cycle, one bubble, then accepted.
REQ-023 i_ready=0 for 3 cycles with o_valid=1 -> outputs stable, o_stall_cnt +3.
REQ-024 jalr rs1_val=0x1001, imm_i=0x2 -> o_pc_target=0x1002; with RV_EXEC_MISALIGN_TRAP_EN o_to_trap=1, without 0.
REQ-025 i_flush and i_valid same cycle -> o_valid=0 next cycle; reset mid-stall -> o_valid=0, o_stall_cnt=0.
REQ-026 mret, i_ret_addr=0x80 -> o_pc_target=0x80, o_inst_jal_jalr=1.
